// File: rtl/fwd_order_scheduler.sv
// fwd_order_scheduler: in-order forwarding scheduler. Finished packets are
// queued by VM index in arrival order. The VM at the queue head either has
// its packet dropped (reject) or is granted the forwarder (accept) before
// the next packet is considered, so packets leave in arrival order.
module fwd_order_scheduler #(
    parameter int N_VM       = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int DEPTH_LOG  = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snoop_done,
    input  logic [SEL_WIDTH-1:0]  snoop_vm,
    input  logic [N_VM-1:0]       vm_dec_vld,
    input  logic [N_VM-1:0]       vm_dec_acc,
    output logic [N_VM-1:0]       vm_dec_ack,
    output logic                  fwd_valid,
    output logic [SEL_WIDTH-1:0]  fwd_vm,
    input  logic                  fwd_ready,
    input  logic                  fwd_done,
    output logic [DEPTH_LOG:0]    order_cnt,
    output logic                  order_ovf,
    output logic [STAT_WIDTH-1:0] fwd_count,
    output logic [STAT_WIDTH-1:0] drop_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [SEL_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG-1:0]   wr_ptr, rd_ptr;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;
    logic [SEL_WIDTH-1:0]   head;
    logic                   head_in_range, head_vld, head_acc;
    logic                   latch_fwd_vm;
    logic                   fwd_inc, drop_inc;
    logic                   ack_en;
    logic [SEL_WIDTH-1:0]   ack_sel;

    assign fifo_full  = (order_cnt == (DEPTH_LOG+1)'(DEPTH));
    assign fifo_empty = (order_cnt == '0);
    assign push       = snoop_done && !fifo_full;
    assign head       = mem[rd_ptr];

    // Storage array written on push only.
    // NOTE: the FIFO storage has no reset; the pointers and count alone define
    // which entries are valid, so resetting the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= snoop_vm;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            order_cnt <= '0;
            order_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      order_cnt <= order_cnt + 1'b1;
            else if (!push && pop) order_cnt <= order_cnt - 1'b1;
            if (snoop_done && fifo_full) order_ovf <= 1'b1;
        end
    end

    // Decode the decision of the head VM; out-of-range indices act as an
    // immediately available reject.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        head_in_range = (32'(head) < N_VM);
        head_vld      = 1'b0;
        head_acc      = 1'b0;
        for (int i = 0; i < N_VM; i++) begin
            if (head == SEL_WIDTH'(i)) begin
                head_vld = vm_dec_vld[i];
                head_acc = vm_dec_acc[i];
            end
        end
        if (!head_in_range) begin
            head_vld = 1'b1;
            head_acc = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_WAIT;
        else      state <= state_nxt;
    end

    // FSM next-state and per-cycle control.
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        fwd_valid    = 1'b0;
        latch_fwd_vm = 1'b0;
        fwd_inc      = 1'b0;
        drop_inc     = 1'b0;
        ack_en       = 1'b0;
        ack_sel      = head;
        case (state)
            ST_WAIT: begin
                if (!fifo_empty && head_vld) begin
                    if (head_acc) begin
                        latch_fwd_vm = 1'b1;
                        state_nxt    = ST_OFFER;
                    end else begin
                        ack_en   = head_in_range;
                        pop      = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
            end
            ST_OFFER: begin
                fwd_valid = 1'b1;
                if (fwd_ready) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (fwd_done) begin
                    ack_en    = 1'b1;
                    ack_sel   = fwd_vm;
                    pop       = 1'b1;
                    fwd_inc   = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    // One-hot acknowledge to the VM whose decision was consumed.
    always_comb begin
        vm_dec_ack = '0;
        for (int i = 0; i < N_VM; i++) begin
            if (ack_en && ack_sel == SEL_WIDTH'(i)) vm_dec_ack[i] = 1'b1;
        end
    end

    // Granted VM index, held stable through OFFER and BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              fwd_vm <= '0;
        else if (latch_fwd_vm) fwd_vm <= head;
    end

    // Saturating forward/drop statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_count  <= '0;
            drop_count <= '0;
        end else begin
            if (fwd_inc && fwd_count != '1)   fwd_count  <= fwd_count + 1'b1;
            if (drop_inc && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule
